// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe scheduler: playfield constants, packed-word layout,
// FSM encoding and the LFSR/random-field helpers used by pipe_scheduler and pipe_lfsr16.
package pipe_pkg;

    localparam int PIPE_SPACING = 210;
    localparam int SCREEN_W     = 640;
    localparam int STEP         = 2;
    localparam int PIPE_HEAD    = 23;
    localparam int Y_SPAN       = 330;
    localparam int GAP_MIN      = 100;
    localparam int GAP_RANGE    = 50;
    localparam int LOCK_X       = 120;

    localparam int GAP_LSB = 20;
    localparam int X_LSB   = 10;
    localparam int Y_LSB   = 0;

    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
    localparam logic [9:0]  Y_MIN        = 10'(PIPE_HEAD);
    localparam logic [9:0]  Y_MAX        = 10'(Y_SPAN - PIPE_HEAD - 1);
    localparam logic [9:0]  RST_Y        = 10'd165;
    localparam logic [7:0]  RST_GAP      = 8'(GAP_MIN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [7:0] gap;
        logic [9:0] x;
        logic [9:0] y;
    } pipe_t;

    // Fibonacci form, taps 16/14/13/11, shifting toward bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    function automatic logic [9:0] rand_y(input logic [15:0] v);
        logic [15:0] m;
        m = v % 16'(Y_SPAN - 2 * PIPE_HEAD);
        return 10'(m) + Y_MIN;
    endfunction

    function automatic logic [7:0] rand_gap(input logic [15:0] v);
        logic [15:0] m;
        m = {8'h00, v[15:8]} % 16'(GAP_RANGE);
        return 8'(m) + 8'(GAP_MIN);
    endfunction

    function automatic logic [31:0] pack_pipe(input pipe_t p);
        logic [31:0] w;
        w = 32'h0;
        w[GAP_LSB +: 8] = p.gap;
        w[X_LSB +: 10]  = p.x;
        w[Y_LSB +: 10]  = p.y;
        return w;
    endfunction

endpackage

// File: rtl/pipe_lfsr16.sv
// Free-running 16-bit LFSR for the pipe scheduler; loads a seed on request and
// never allows the all-zero lock-up state in via the seed.
module pipe_lfsr16
    import pipe_pkg::*;
(
    input  logic        clk_100ms,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic [15:0] lfsr_reg;

    always_ff @(posedge clk_100ms or negedge rst) begin
        if (!rst) begin
            lfsr_reg <= LFSR_DEFAULT;
        end else if (load) begin
            lfsr_reg <= (seed == 16'h0000) ? LFSR_DEFAULT : seed;
        end else begin
            lfsr_reg <= lfsr_step(lfsr_reg);
        end
    end

    assign value = lfsr_reg;

endmodule

// File: rtl/pipe_scheduler.sv
// Scrolls, respawns and arbitrates the three flappy-bird pipe slots on the game tick.
// Build option PIPE_SCHED_ADJ_EN enables player-2 adjust and owner tracking.
module pipe_scheduler
    import pipe_pkg::*;
(
    input  logic        clk_100ms,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] seed,
    input  logic        run,
    input  logic        mode,
    input  logic        adj_up,
    input  logic        adj_down,
    output logic [31:0] pipe1,
    output logic [31:0] pipe2,
    output logic [31:0] pipe3,
    output logic [1:0]  owner,
    output logic        spawn,
    output logic [1:0]  spawn_slot
);

`ifdef PIPE_SCHED_ADJ_EN
    localparam bit ADJ_EN = 1'b1;
`else
    localparam bit ADJ_EN = 1'b0;
`endif

    sched_state_t state_reg, state_next;
    pipe_t        slot_reg  [3];
    pipe_t        slot_next [3];
    logic [1:0]   owner_reg, owner_next;
    logic         spawn_reg, spawn_next;
    logic [1:0]   spawn_slot_reg, spawn_slot_next;

    logic [15:0]  lfsr_value;
    logic [15:0]  rnd [3];
    logic [2:0]   pending;
    logic [2:0]   grant;
    logic [1:0]   grant_idx;
    logic [2:0]   adj_sel;
    logic [9:0]   adj_y;
    logic [31:0]  pipe_word [3];

    pipe_lfsr16 u_lfsr (
        .clk_100ms (clk_100ms),
        .rst       (rst),
        .load      (start),
        .seed      (seed),
        .value     (lfsr_value)
    );

    // LOAD seeds all three slots in one tick from the current value and two look-ahead steps.
    assign rnd[0] = lfsr_value;

    genvar gi;
    generate
        for (gi = 1; gi < 3; gi++) begin : g_rnd
            assign rnd[gi] = lfsr_step(rnd[gi-1]);
        end
        for (gi = 0; gi < 3; gi++) begin : g_slot
            assign pending[gi]   = (slot_reg[gi].x <= 10'(STEP));
            assign pipe_word[gi] = pack_pipe(slot_reg[gi]);
        end
    endgenerate

    always_comb begin
        grant     = 3'b000;
        grant_idx = 2'd0;
        if (pending[0]) begin
            grant     = 3'b001;
            grant_idx = 2'd1;
        end else if (pending[1]) begin
            grant     = 3'b010;
            grant_idx = 2'd2;
        end else if (pending[2]) begin
            grant     = 3'b100;
            grant_idx = 2'd3;
        end
    end

`ifdef PIPE_SCHED_ADJ_EN
    logic [2:0] owner_onehot;
    pipe_t      own_pipe;

    generate
        for (gi = 0; gi < 3; gi++) begin : g_own
            assign owner_onehot[gi] = (owner_reg == 2'(gi + 1));
        end
    endgenerate

    always_comb begin
        own_pipe = slot_reg[0];
        case (owner_reg)
            2'd2:    own_pipe = slot_reg[1];
            2'd3:    own_pipe = slot_reg[2];
            default: own_pipe = slot_reg[0];
        endcase

        adj_y = own_pipe.y;
        if (adj_up && !adj_down && (own_pipe.y < Y_MAX)) begin
            adj_y = own_pipe.y + 10'd1;
        end else if (adj_down && !adj_up && (own_pipe.y > Y_MIN)) begin
            adj_y = own_pipe.y - 10'd1;
        end

        // owner_onehot is all-zero when owner is 0, so no slot is selected then.
        adj_sel = 3'b000;
        if (mode && (own_pipe.x >= 10'(LOCK_X))) begin
            adj_sel = owner_onehot;
        end
    end
`else
    logic unused_adj;
    assign unused_adj = ^{mode, adj_up, adj_down};
    assign adj_sel    = 3'b000;
    assign adj_y      = 10'd0;
`endif

    always_comb begin
        state_next      = state_reg;
        slot_next       = slot_reg;
        owner_next      = owner_reg;
        spawn_next      = 1'b0;
        spawn_slot_next = spawn_slot_reg;

        if (start) begin
            state_next = LOAD;
        end else begin
            case (state_reg)
                IDLE: state_next = IDLE;
                LOAD: begin
                    for (int k = 0; k < 3; k++) begin
                        slot_next[k].x   = 10'(PIPE_SPACING * (k + 1));
                        slot_next[k].y   = rand_y(rnd[k]);
                        slot_next[k].gap = rand_gap(rnd[k]);
                    end
                    owner_next = ADJ_EN ? 2'd3 : 2'd0;
                    state_next = run ? RUN : HOLD;
                end
                RUN: begin
                    // A respawn overrides any adjust on the same slot.
                    for (int k = 0; k < 3; k++) begin
                        if (grant[k]) begin
                            slot_next[k].x   = 10'(SCREEN_W);
                            slot_next[k].y   = rand_y(lfsr_value);
                            slot_next[k].gap = rand_gap(lfsr_value);
                        end else begin
                            slot_next[k].x = pending[k] ? 10'd0 : (slot_reg[k].x - 10'(STEP));
                            if (adj_sel[k]) begin
                                slot_next[k].y = adj_y;
                            end
                        end
                    end
                    if (grant != 3'b000) begin
                        spawn_next      = 1'b1;
                        spawn_slot_next = grant_idx;
                        owner_next      = ADJ_EN ? grant_idx : 2'd0;
                    end
                    state_next = run ? RUN : HOLD;
                end
                HOLD: state_next = run ? RUN : HOLD;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_100ms or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            for (int k = 0; k < 3; k++) begin
                slot_reg[k].gap <= RST_GAP;
                slot_reg[k].x   <= 10'(PIPE_SPACING * (k + 1));
                slot_reg[k].y   <= RST_Y;
            end
            owner_reg      <= 2'd0;
            spawn_reg      <= 1'b0;
            spawn_slot_reg <= 2'd0;
        end else begin
            state_reg      <= state_next;
            slot_reg       <= slot_next;
            owner_reg      <= owner_next;
            spawn_reg      <= spawn_next;
            spawn_slot_reg <= spawn_slot_next;
        end
    end

    assign pipe1      = pipe_word[0];
    assign pipe2      = pipe_word[1];
    assign pipe3      = pipe_word[2];
    assign owner      = owner_reg;
    assign spawn      = spawn_reg;
    assign spawn_slot = spawn_slot_reg;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Scoreboard bench for pipe_scheduler: the stimulus side pushes expected outputs from a
// behavioural playfield model, a monitor pops and compares one entry per game tick.
module tb_pipe_scheduler;

`ifdef PIPE_SCHED_ADJ_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        clk_100ms = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] seed = 16'h0;
    logic        run = 1'b0;
    logic        mode = 1'b0;
    logic        adj_up = 1'b0;
    logic        adj_down = 1'b0;
    logic [31:0] pipe1, pipe2, pipe3;
    logic [1:0]  owner;
    logic        spawn;
    logic [1:0]  spawn_slot;

    pipe_scheduler dut (
        .clk_100ms  (clk_100ms),
        .rst        (rst),
        .start      (start),
        .seed       (seed),
        .run        (run),
        .mode       (mode),
        .adj_up     (adj_up),
        .adj_down   (adj_down),
        .pipe1      (pipe1),
        .pipe2      (pipe2),
        .pipe3      (pipe3),
        .owner      (owner),
        .spawn      (spawn),
        .spawn_slot (spawn_slot)
    );

    always #5 clk_100ms = ~clk_100ms;

    typedef struct {
        logic [31:0] p1, p2, p3;
        logic [1:0]  own;
        logic        sp;
        logic [1:0]  slot;
        int          hand_x1;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference playfield model.
    int          mx[3], my[3], mg[3];
    int          mown, mslot, mstate;
    bit          mspawn;
    logic [15:0] mlfsr;

    function automatic logic [15:0] ref_step(input logic [15:0] l);
        logic fb;
        fb = l[0] ^ l[2] ^ l[3] ^ l[5];
        return (l >> 1) | {fb, 15'h0};
    endfunction

    function automatic int ref_y(input logic [15:0] l);
        return 23 + (int'(l) % 284);
    endfunction

    function automatic int ref_gap(input logic [15:0] l);
        logic [7:0] hi;
        hi = l[15:8];
        return 100 + (int'(hi) % 50);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mx[k] = 210 * (k + 1);
            my[k] = 165;
            mg[k] = 100;
        end
        mown = 0; mslot = 0; mspawn = 0; mstate = 0; mlfsr = 16'hACE1;
    endtask

    task automatic model_step(input bit st, input logic [15:0] sd, input bit rn,
                              input bit md, input bit up, input bit dn);
        logic [15:0] v;
        int g;
        mspawn = 0;
        if (st) begin
            mlfsr  = (sd == 16'h0) ? 16'hACE1 : sd;
            mstate = 1;
            return;
        end
        case (mstate)
            1: begin
                v = mlfsr;
                for (int k = 0; k < 3; k++) begin
                    mx[k] = 210 * (k + 1);
                    my[k] = ref_y(v);
                    mg[k] = ref_gap(v);
                    v = ref_step(v);
                end
                mown   = EN ? 3 : 0;
                mstate = rn ? 2 : 3;
            end
            2: begin
                g = -1;
                for (int k = 0; k < 3; k++) if (mx[k] <= 2 && g < 0) g = k;
                if (EN && md && mown != 0 && mx[mown-1] >= 120 && g != mown - 1) begin
                    if (up && !dn && my[mown-1] < 306) my[mown-1] = my[mown-1] + 1;
                    else if (dn && !up && my[mown-1] > 23) my[mown-1] = my[mown-1] - 1;
                end
                for (int k = 0; k < 3; k++) begin
                    if (k == g) begin
                        mx[k] = 640;
                        my[k] = ref_y(mlfsr);
                        mg[k] = ref_gap(mlfsr);
                    end else if (mx[k] <= 2) begin
                        mx[k] = 0;
                    end else begin
                        mx[k] = mx[k] - 2;
                    end
                end
                if (g >= 0) begin
                    mspawn = 1;
                    mslot  = g + 1;
                    if (EN) mown = g + 1;
                end
                mstate = rn ? 2 : 3;
            end
            3: mstate = rn ? 2 : 3;
            default: ;
        endcase
        mlfsr = ref_step(mlfsr);
    endtask

    function automatic logic [31:0] word(input int k);
        return {4'h0, 8'(mg[k]), 10'(mx[k]), 10'(my[k])};
    endfunction

    task automatic tick(input bit r, input bit st, input logic [15:0] sd, input bit rn,
                        input bit md, input bit up, input bit dn, input int hx);
        exp_t e;
        @(negedge clk_100ms);
        rst = r; start = st; seed = sd; run = rn; mode = md; adj_up = up; adj_down = dn;
        if (!r) model_reset();
        else model_step(st, sd, rn, md, up, dn);
        e.p1 = word(0); e.p2 = word(1); e.p3 = word(2);
        e.own = 2'(mown); e.sp = mspawn; e.slot = 2'(mslot); e.hand_x1 = hx;
        sb.push_back(e);
    endtask

    // Monitor: every tick the DUT presents a full set of registered outputs.
    initial begin
        exp_t e;
        bit ok;
        forever begin
            @(posedge clk_100ms);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                ok = (pipe1 === e.p1) && (pipe2 === e.p2) && (pipe3 === e.p3) &&
                     (owner === e.own) && (spawn === e.sp) && (spawn_slot === e.slot);
                if (e.hand_x1 >= 0 && pipe1[19:10] !== 10'(e.hand_x1)) ok = 0;
                if (!ok) begin
                    miscompares++;
                    $display("FAIL vec%0d outputs: got p1=%h p2=%h p3=%h own=%0d sp=%0b slot=%0d, expected p1=%h p2=%h p3=%h own=%0d sp=%0b slot=%0d hand_x1=%0d",
                             vectors, pipe1, pipe2, pipe3, owner, spawn, spawn_slot,
                             e.p1, e.p2, e.p3, e.own, e.sp, e.slot, e.hand_x1);
                end else begin
                    $display("vec%0d ok p1=%h p2=%h p3=%h own=%0d sp=%0b slot=%0d",
                             vectors, pipe1, pipe2, pipe3, owner, spawn, spawn_slot);
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) tick(0, 0, 16'h0, 0, 0, 0, 0, 210);
        repeat (10) tick(1, 0, 16'h0, 0, 0, 0, 0, 210);
        tick(1, 1, 16'h0001, 1, 0, 0, 0, 210);
        tick(1, 0, 16'h0, 1, 0, 0, 0, 210);
        for (int i = 1; i <= 104; i++) tick(1, 0, 16'h0, 1, 0, 0, 0, (i == 104) ? 2 : -1);
        tick(1, 0, 16'h0, 1, 0, 0, 0, 640);
        repeat (150) tick(1, 0, 16'h0, 1, 1, 1, 0, -1);
        repeat (10)  tick(1, 0, 16'h0, 1, 1, 1, 1, -1);
        repeat (220) tick(1, 0, 16'h0, 1, 1, 0, 1, -1);
        repeat (20)  tick(1, 0, 16'h0, 0, 1, 1, 0, -1);
        repeat (30)  tick(1, 0, 16'h0, 1, 0, 0, 0, -1);
        repeat (2)   tick(0, 0, 16'h0, 1, 0, 0, 0, 210);
        tick(1, 1, 16'h0000, 0, 0, 0, 0, 210);
        repeat (5)   tick(1, 0, 16'h0, 0, 1, 0, 1, 210);
        repeat (40)  tick(1, 0, 16'h0, 1, 1, 0, 1, -1);
        repeat (3) @(posedge clk_100ms);
        #2;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
